// File: rtl/pwm_pkg.sv
// Package shared by the PWM blocks.
//   state_e            : capture FSM state encodings
//   PWM_WIDTH_DEFAULT  : default counter width, common with the PWM generator
package pwm_pkg;

  localparam int PWM_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    MEAS_HIGH = 2'd1,
    MEAS_LOW  = 2'd2
  } state_e;

endpackage

// File: rtl/pwm_capture_if.sv
// Measurement result bus of pwm_capture.
//   period    : last measured period in ticks
//   high_time : last measured high time in ticks
//   valid     : one-cycle strobe, period/high_time updated in this cycle
//   timeout   : level, counter saturated before the expected edge
// Handshake: valid-only strobe with no ready/back-pressure. The consumer must
// take period/high_time in the cycle valid is high; the values also hold
// until the next valid, so a late reader still sees the latest measurement.
interface pwm_capture_if #(
  parameter int WIDTH = pwm_pkg::PWM_WIDTH_DEFAULT
);
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic             valid;
  logic             timeout;

  modport master (output period, output high_time, output valid, output timeout);
  modport slave  (input  period, input  high_time, input  valid, input  timeout);
endinterface

// File: rtl/pwm_edge_sync.sv
// Synchroniser and edge detector for an asynchronous PWM line.
//   clk, rst : system clock, synchronous active-high reset
//   pwm_in   : asynchronous input line
//   rise     : one-cycle pulse, synchronised line went 0->1
//   fall     : one-cycle pulse, synchronised line went 1->0
// SYNC_STAGES must be at least 2. Edges appear SYNC_STAGES+1 clocks after
// the input transition (counting the edge the FSM acts on).
module pwm_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pwm_in};
    dly_d  = s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  // Both pulses come from the same flop pair, so they can never coincide.
  assign rise = s & ~dly_q;
  assign fall = ~s & dly_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM input measurement: period (rise to rise) and high time (rise to fall)
// counted in tick-enabled cycles.
//   clk, rst  : system clock, synchronous active-high reset
//   enable    : measurement enable; low forces a fresh start
//   tick      : count enable (prescaler pulse, or tied high)
//   pwm_in    : asynchronous PWM line
//   meas      : result bus (period, high_time, valid, timeout)
//   dbg_state : current FSM state
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int WIDTH       = PWM_WIDTH_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            tick,
  input  logic            pwm_in,
  pwm_capture_if.master   meas,
  output state_e          dbg_state
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic rise, fall;

  pwm_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
    .clk    (clk),
    .rst    (rst),
    .pwm_in (pwm_in),
    .rise   (rise),
    .fall   (fall)
  );

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_cap_q, hi_cap_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] high_time_q, high_time_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  // cnt_next is cnt+tick, saturating; it is both the running count and the
  // value sampled on an edge cycle. sat flags the cycle that would overflow.
  logic [WIDTH-1:0] cnt_next;
  logic             sat;

  always_comb begin
    cnt_next = cnt_q;
    if (tick && (cnt_q != CNT_MAX)) cnt_next = cnt_q + WIDTH'(1);
    sat = tick && (cnt_q == CNT_MAX);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_next;
    hi_cap_d    = hi_cap_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    valid_d     = 1'b0;
    timeout_d   = timeout_q;

    if (!enable) begin
      state_d = WAIT_RISE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        WAIT_RISE: begin
          cnt_d = '0;
          if (rise) state_d = MEAS_HIGH;
        end
        MEAS_HIGH: begin
          // Edge handling wins over saturation on the same cycle.
          if (fall) begin
            hi_cap_d = cnt_next;
            state_d  = MEAS_LOW;
          end else if (sat) begin
            timeout_d = 1'b1;
            state_d   = WAIT_RISE;
          end
        end
        MEAS_LOW: begin
          if (rise) begin
            period_d    = cnt_next;
            high_time_d = hi_cap_q;
            valid_d     = 1'b1;
            timeout_d   = 1'b0;
            cnt_d       = '0;
            state_d     = MEAS_HIGH;
          end else if (sat) begin
            timeout_d = 1'b1;
            state_d   = WAIT_RISE;
          end
        end
        default: begin
          state_d = WAIT_RISE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_RISE;
      cnt_q       <= '0;
      hi_cap_q    <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_cap_q    <= hi_cap_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign meas.period    = period_q;
  assign meas.high_time = high_time_q;
  assign meas.valid     = valid_q;
  assign meas.timeout   = timeout_q;
  assign dbg_state      = state_q;

endmodule
